// File: rtl/yousei_disp_pkg.sv
// Shared display definitions: segment bit order, hex glyph patterns and the
// nibble-to-segment decode used by every display path.
package yousei_disp_pkg;

    localparam int SEG_BIT_A = 0;
    localparam int SEG_BIT_G = 6;
    localparam int SEG_W     = SEG_BIT_G - SEG_BIT_A + 1;

    // Active-high patterns, bit order gfedcba
    localparam logic [SEG_W-1:0] SEG_0   = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1   = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2   = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3   = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4   = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5   = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6   = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7   = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8   = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9   = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A   = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B   = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C   = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D   = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E   = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F   = 7'h71;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = SEG_0;
            4'h1: hex_to_seg = SEG_1;
            4'h2: hex_to_seg = SEG_2;
            4'h3: hex_to_seg = SEG_3;
            4'h4: hex_to_seg = SEG_4;
            4'h5: hex_to_seg = SEG_5;
            4'h6: hex_to_seg = SEG_6;
            4'h7: hex_to_seg = SEG_7;
            4'h8: hex_to_seg = SEG_8;
            4'h9: hex_to_seg = SEG_9;
            4'hA: hex_to_seg = SEG_A;
            4'hB: hex_to_seg = SEG_B;
            4'hC: hex_to_seg = SEG_C;
            4'hD: hex_to_seg = SEG_D;
            4'hE: hex_to_seg = SEG_E;
            default: hex_to_seg = SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble -> active-high gfedcba segment pattern.
// Zero latency, no flow control; shared by any path that renders a hex digit.
module hex_to_7seg
    import yousei_disp_pkg::*;
(
    input  logic [3:0]       in_nib,
    output logic [SEG_W-1:0] out_seg
);

    assign out_seg = hex_to_seg(in_nib);

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode hex display driver with anode-off guard per dwell,
// frame-aligned double-buffered loads and optional leading-zero blanking.
module seven_seg_scanner
    import yousei_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_BITS = 16,
    parameter int GUARD_CYCLES = 64,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit AN_ACT_LOW   = 1'b1
) (
    input  logic                    iclk,
    input  logic                    irst,
    input  logic [4*NUM_DIGITS-1:0] in_value,
    input  logic [NUM_DIGITS-1:0]   in_dp,
    input  logic                    in_load,
    input  logic                    in_lz_blank,
    output logic [6:0]              out_seg,
    output logic                    out_dp,
    output logic [NUM_DIGITS-1:0]   out_an,
    output logic                    out_frame
);

    localparam int                      IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [REFRESH_BITS-1:0] GUARD    = REFRESH_BITS'(GUARD_CYCLES);
    localparam logic [6:0]              SEG_INV  = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic                    DP_INV   = SEG_ACT_LOW;
    localparam logic [NUM_DIGITS-1:0]   AN_INV   = AN_ACT_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [REFRESH_BITS-1:0] dwell_q, dwell_d;
    logic [IDX_W-1:0]        digit_q, digit_d;
    logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d, pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_q, frame_d;

    logic                    dwell_wrap;
    logic                    at_boundary;
    logic [3:0]              cur_nib;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   lz_chain;
    logic                    lz_run;
    logic                    blank;

    hex_to_7seg u_dec (
        .in_nib  (cur_nib),
        .out_seg (dec_seg)
    );

    always_comb begin
        dwell_wrap  = (dwell_q == {REFRESH_BITS{1'b1}});
        at_boundary = dwell_wrap && (digit_q == LAST_IDX);
        dwell_d     = dwell_q + 1'b1;
        digit_d     = digit_q;
        if (dwell_wrap) begin
            digit_d = (digit_q == LAST_IDX) ? '0 : digit_q + 1'b1;
        end
        // Look one state ahead so the registered pulse lands on the boundary cycle itself
        frame_d = (dwell_d == {REFRESH_BITS{1'b1}}) && (digit_d == LAST_IDX);
    end

    always_comb begin
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        if (at_boundary && in_load) begin
            disp_val_d = in_value;
            disp_dp_d  = in_dp;
            pend_vld_d = 1'b0;
        end else if (at_boundary && pend_vld_q) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
            pend_vld_d = 1'b0;
        end else if (in_load) begin
            pend_val_d = in_value;
            pend_dp_d  = in_dp;
            pend_vld_d = 1'b1;
        end
    end

    always_comb begin
        cur_nib  = disp_val_q[{digit_q, 2'b00} +: 4];
        lz_run   = 1'b1;
        lz_chain = '0;
        // lz_chain[i]: every nibble from the top down to i is zero
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run      = lz_run && (disp_val_q[4*i +: 4] == 4'h0);
            lz_chain[i] = lz_run;
        end
        blank = in_lz_blank && (digit_q != '0) && lz_chain[digit_q];

        an_d  = AN_INV;
        seg_d = SEG_OFF ^ SEG_INV;
        dp_d  = DP_INV;
        if (dwell_q >= GUARD) begin
            an_d  = AN_INV ^ (NUM_DIGITS'(1) << digit_q);
            seg_d = (blank ? SEG_OFF : dec_seg) ^ SEG_INV;
            dp_d  = disp_dp_q[digit_q] ^ DP_INV;
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            dwell_q    <= '0;
            digit_q    <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            seg_q      <= SEG_OFF ^ SEG_INV;
            dp_q       <= DP_INV;
            an_q       <= AN_INV;
            frame_q    <= 1'b0;
        end else begin
            dwell_q    <= dwell_d;
            digit_q    <= digit_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            frame_q    <= frame_d;
        end
    end

    assign out_seg   = seg_q;
    assign out_dp    = dp_q;
    assign out_an    = an_q;
    assign out_frame = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized bench for seven_seg_scanner (4 digits, 16-cycle dwell, 2-cycle guard,
// active-low) against a cycle-count based behavioural model.
module tb_seven_seg_scanner;

    logic        iclk = 1'b0;
    logic        irst;
    logic [15:0] in_value;
    logic [3:0]  in_dp;
    logic        in_load;
    logic        in_lz_blank;
    logic [6:0]  out_seg;
    logic        out_dp;
    logic [3:0]  out_an;
    logic        out_frame;

    always #5 iclk = ~iclk;

    seven_seg_scanner #(
        .NUM_DIGITS   (4),
        .REFRESH_BITS (4),
        .GUARD_CYCLES (2),
        .SEG_ACT_LOW  (1'b1),
        .AN_ACT_LOW   (1'b1)
    ) dut (
        .iclk        (iclk),
        .irst        (irst),
        .in_value    (in_value),
        .in_dp       (in_dp),
        .in_load     (in_load),
        .in_lz_blank (in_lz_blank),
        .out_seg     (out_seg),
        .out_dp      (out_dp),
        .out_an      (out_an),
        .out_frame   (out_frame)
    );

    int checks   = 0;
    int failures = 0;

    logic [6:0] glyph [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: m_t counts clean cycles since reset; dwell = m_t%16, digit = (m_t/16)%4
    int          m_t;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_dp, m_pdp;
    logic        m_pvld;
    logic [12:0] exp_out;
    logic [12:0] obs;
    assign obs = {out_frame, out_dp, out_an, out_seg};

    task automatic model_edge();
        int          dwell, dig;
        logic [15:0] sh;
        logic        blank;
        if (irst) begin
            exp_out = {1'b0, 1'b1, 4'hF, 7'h7F};
            m_t = 0; m_disp = '0; m_dp = '0; m_pend = '0; m_pdp = '0; m_pvld = 1'b0;
        end else begin
            dwell = m_t % 16;
            dig   = (m_t / 16) % 4;
            if (dwell < 2) begin
                exp_out = {1'b0, 1'b1, 4'hF, 7'h7F};
            end else begin
                sh    = m_disp >> (4 * dig);
                blank = in_lz_blank && (dig != 0) && (sh == 16'h0);
                exp_out[6:0]  = blank ? 7'h7F : ~glyph[sh[3:0]];
                exp_out[10:7] = ~(4'b0001 << dig);
                exp_out[11]   = ~m_dp[dig];
            end
            exp_out[12] = (((m_t + 1) % 64) == 63);
            if ((m_t % 64) == 63) begin
                if (in_load) begin
                    m_disp = in_value; m_dp = in_dp; m_pvld = 1'b0;
                end else if (m_pvld) begin
                    m_disp = m_pend; m_dp = m_pdp; m_pvld = 1'b0;
                end
            end else if (in_load) begin
                m_pend = in_value; m_pdp = in_dp; m_pvld = 1'b1;
            end
            m_t++;
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        irst = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (obs !== {1'b0, 1'b1, 4'hF, 7'h7F}) begin
                failures++;
                $display("FAIL reset_hold got %h expected %h", obs, 13'h0FFF);
            end
        end
        irst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (out_an !== ((c == 3) ? 4'b1110 : 4'b1111)) begin
                failures++;
                $display("FAIL reset_release c=%0d an got %h expected %h", c, out_an,
                         (c == 3) ? 4'b1110 : 4'b1111);
            end
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL reset_model c=%0d got %h expected %h", c, obs, exp_out);
            end
        end
    endtask

    task automatic test_scan();
        in_value = 16'h1234; in_dp = 4'($urandom); in_load = 1'b1;
        tick();
        in_load = 1'b0;
        repeat (140) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL scan t=%0d got %h expected %h", m_t, obs, exp_out);
            end
        end
    endtask

    task automatic test_tear_free();
        for (int k = 0; k < 64 && (m_t % 64) != 20; k++) tick();
        in_value = 16'hAAAA; in_dp = 4'($urandom); in_load = 1'b1;
        tick();
        in_load = 1'b0;
        repeat (140) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL tear_free t=%0d got %h expected %h", m_t, obs, exp_out);
            end
        end
    endtask

    task automatic test_boundary();
        for (int k = 0; k < 64 && (m_t % 64) != 63; k++) tick();
        checks++;
        if (out_frame !== 1'b1) begin
            failures++;
            $display("FAIL frame_pulse got %b expected 1", out_frame);
        end
        in_value = 16'h00F0; in_dp = 4'b0100; in_load = 1'b1;
        tick();
        in_load = 1'b0;
        repeat (70) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL boundary_load t=%0d got %h expected %h", m_t, obs, exp_out);
            end
        end
        in_value = 16'h0001; in_dp = 4'($urandom); in_load = 1'b1;
        tick();
        in_load = 1'b0;
        repeat (10) tick();
        in_value = 16'h0002; in_dp = 4'($urandom); in_load = 1'b1;
        tick();
        in_load = 1'b0;
        repeat (130) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL last_wins t=%0d got %h expected %h", m_t, obs, exp_out);
            end
        end
    endtask

    task automatic test_lz_blank();
        in_lz_blank = 1'b1;
        foreach (glyph[j]) begin
            if (j == 0 || j == 5) begin
                in_value = (j == 5) ? 16'h0005 : 16'h0000;
                in_dp = 4'($urandom); in_load = 1'b1;
                tick();
                in_load = 1'b0;
                repeat (130) begin
                    tick();
                    checks++;
                    if (obs !== exp_out) begin
                        failures++;
                        $display("FAIL lz_blank val=%0d t=%0d got %h expected %h", j, m_t, obs, exp_out);
                    end
                end
            end
        end
        in_lz_blank = 1'b0;
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 64 && (m_t % 64) != 2; k++) tick();
        in_value = 16'h9C3B; in_dp = 4'hF; in_load = 1'b1;
        tick();
        in_load = 1'b0;
        for (int k = 0; k < 64 && (m_t % 64) != 40; k++) tick();
        irst = 1'b1;
        repeat (2) begin
            tick();
            checks++;
            if (obs !== {1'b0, 1'b1, 4'hF, 7'h7F}) begin
                failures++;
                $display("FAIL mid_reset got %h expected %h", obs, 13'h0FFF);
            end
        end
        irst = 1'b0;
        repeat (130) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL after_reset t=%0d got %h expected %h", m_t, obs, exp_out);
            end
        end
    endtask

    task automatic test_random();
        repeat (2000) begin
            in_load = ($urandom_range(0, 19) == 0);
            if (in_load) begin
                in_value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
                in_dp    = 4'($urandom);
            end
            if ($urandom_range(0, 49) == 0) in_lz_blank = ~in_lz_blank;
            tick();
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL random t=%0d got %h expected %h", m_t, obs, exp_out);
            end
        end
        in_load = 1'b0;
    endtask

    initial begin
        irst = 1'b1; in_value = '0; in_dp = '0; in_load = 1'b0; in_lz_blank = 1'b0;
        m_t = 0; m_disp = '0; m_dp = '0; m_pend = '0; m_pdp = '0; m_pvld = 1'b0;
        exp_out = '0;
        test_reset();
        test_scan();
        test_tear_free();
        test_boundary();
        test_lz_blank();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
